// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the system bus arbiter: FSM encoding and default sizing.
package bus_arbiter_pkg;

    localparam int unsigned DefNumReq        = 4;
    localparam int unsigned DefTimeoutCycles = 64;
    localparam int unsigned DefIdW           = 3;
    localparam int unsigned TimerW           = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StGrant = 3'b010,
        StTurn  = 3'b100
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set bit of eligible_i at or after ptr_i, wrapping.
module bus_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        // Outer loop is the scan distance from ptr_i, so the nearest hit wins.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!valid_o && eligible_i[i] && (((32'(ptr_i) + k) % NUM_REQ) == i)) begin
                    valid_o = 1'b1;
                    idx_o   = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter with a turnaround cycle between owners and a hold watchdog.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DefNumReq,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
    parameter int unsigned ID_W           = DefIdW
) (
    input  logic               bus_clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] br_i,
    output logic [NUM_REQ-1:0] bg_o,
    output logic               bus_busy_o,
    output logic [ID_W-1:0]    owner_o,
    output logic               timeout_err_o,
    input  logic               err_clr_i
);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  bg_q, bg_d;
    logic                busy_q, busy_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [NUM_REQ-1:0]  lockout_q, lockout_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  pick_oh;
    logic                pick_valid;
    logic [ID_W-1:0]     pick_idx;
    logic                owner_req;
    logic                timer_hit;
    logic [ID_W-1:0]     owner_next;

    assign eligible  = br_i & ~lockout_q;
    // bg_q is one-hot on the owner while granted, so this is BR[owner].
    assign owner_req = |(br_i & bg_q);
    assign timer_hit = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));
    assign owner_next = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    bus_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .valid_o    (pick_valid),
        .idx_o      (pick_idx)
    );

    always_comb begin
        pick_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pick_oh[i] = (pick_idx == ID_W'(i));
        end
    end

    always_ff @(posedge bus_clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_valid) state_d = StGrant;
            StGrant: if (!owner_req || timer_hit) state_d = StTurn;
            StTurn:  state_d = pick_valid ? StGrant : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bg_d      = bg_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        lockout_d = lockout_q & br_i;
        err_d     = err_q & ~err_clr_i;
        unique case (state_q)
            StIdle, StTurn: begin
                bg_d = '0;
                if (pick_valid) begin
                    bg_d    = pick_oh;
                    owner_d = pick_idx;
                    timer_d = '0;
                end
            end
            StGrant: begin
                timer_d = timer_q + 1'b1;
                if (!owner_req) begin
                    bg_d  = '0;
                    ptr_d = owner_next;
                end else if (timer_hit) begin
                    // Set after the clear above so a same-cycle ERR_CLR loses.
                    bg_d      = '0;
                    ptr_d     = owner_next;
                    lockout_d = lockout_d | bg_q;
                    err_d     = 1'b1;
                end
            end
            default: bg_d = '0;
        endcase
        busy_d = |bg_d;
    end

    always_ff @(posedge bus_clk_i) begin
        if (rst_i) begin
            bg_q      <= '0;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            ptr_q     <= '0;
            timer_q   <= '0;
            lockout_q <= '0;
            err_q     <= 1'b0;
        end else begin
            bg_q      <= bg_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            lockout_q <= lockout_d;
            err_q     <= err_d;
        end
    end

    assign bg_o          = bg_q;
    assign bus_busy_o    = busy_q;
    assign owner_o       = owner_q;
    assign timeout_err_o = err_q;

    bg_onehot_a: assert property (@(posedge bus_clk_i) $onehot0(bg_q));

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random BR traffic against a behavioural model.
module tb_bus_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned TO  = 16;
    localparam int unsigned IDW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clr = 1'b0;
    logic [N-1:0]   br  = '0;
    logic [N-1:0]   bg;
    logic           busy;
    logic [IDW-1:0] owner;
    logic           err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: which requester holds the bus (-1 = free), for how many edges, and arbitration state.
    int           m_own  = -1;
    int           m_last = 0;
    int           m_ptr  = 0;
    int           m_held = 0;
    bit [N-1:0]   m_lock = '0;
    bit           m_err  = 1'b0;
    logic [N-1:0] prev_bg = '0;

    int           cnt [N];
    int           order[$];
    int           exp_ord [5] = '{0, 1, 2, 3, 0};
    int           hi;
    logic [N-1:0] rb;
    logic [N-1:0] old_bg;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO),
        .ID_W           (IDW)
    ) dut (
        .bus_clk_i     (clk),
        .rst_i         (rst),
        .br_i          (br),
        .bg_o          (bg),
        .bus_busy_o    (busy),
        .owner_o       (owner),
        .timeout_err_o (err),
        .err_clr_i     (clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int first_from(input bit [N-1:0] elig, input int start);
        for (int k = 0; k < N; k++) begin
            if (elig[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Applies the arbitration rules for one clock edge using the inputs sampled at that edge.
    task automatic model_edge();
        bit [N-1:0] elig;
        int         p;
        if (rst) begin
            m_own = -1; m_last = 0; m_ptr = 0; m_held = 0; m_lock = '0; m_err = 1'b0;
            return;
        end
        elig   = br & ~m_lock;
        m_lock = m_lock & br;
        m_err  = m_err && !clr;
        if (m_own >= 0) begin
            if (!br[m_own]) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end else if (m_held == TO - 1) begin
                m_lock[m_own] = 1'b1;
                m_err = 1'b1;
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end else begin
                m_held++;
            end
        end else begin
            // A release edge never grants, which yields the dead cycle between owners.
            p = first_from(elig, m_ptr);
            if (p >= 0) begin
                m_own = p; m_last = p; m_held = 0;
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] b, input logic c, input logic r);
        logic [N-1:0] exp_bg;
        br = b; clr = c; rst = r;
        @(posedge clk);
        model_edge();
        #1;
        exp_bg = '0;
        if (m_own >= 0) exp_bg[m_own] = 1'b1;
        check_eq("bg", 32'(bg), 32'(exp_bg));
        check_eq("busy", 32'(busy), 32'(m_own >= 0));
        check_eq("owner", 32'(owner), 32'(m_last));
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("onehot0", 32'($onehot0(bg)), 32'd1);
        if (prev_bg != '0 && bg != '0) check_eq("turnaround", 32'(bg), 32'(prev_bg));
        prev_bg = bg;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        // Single request latency and release pointer update.
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0100, 1'b0, 1'b0);
        check_eq("s1_bg", 32'(bg), 32'(4'b0100));
        check_eq("s1_owner", 32'(owner), 32'd2);
        repeat (4) cycle(4'b0100, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        check_eq("s1_drop", 32'(bg), 32'd0);
        cycle(4'b1111, 1'b0, 1'b0);
        check_eq("s1_ptr", 32'(bg), 32'(4'b1000));
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);

        // All requesting, each releasing after four grant cycles.
        cycle(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int t = 0; t < 80 && order.size() < 5; t++) begin
            rb = '1;
            for (int i = 0; i < N; i++) begin
                if (cnt[i] >= 4) begin
                    rb[i] = 1'b0;
                    cnt[i] = 0;
                end
            end
            old_bg = prev_bg;
            cycle(rb, 1'b0, 1'b0);
            if (m_own >= 0) cnt[m_own]++;
            if (old_bg == '0 && bg != '0) begin
                for (int i = 0; i < N; i++) if (bg[i]) order.push_back(i);
            end
        end
        check_eq("s2_count", 32'(order.size()), 32'd5);
        for (int k = 0; k < 5 && k < order.size(); k++) begin
            check_eq("s2_order", 32'(order[k]), 32'(exp_ord[k]));
        end

        // No preemption; next grant skips a non-requesting index.
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b0);
        check_eq("s3_grant", 32'(bg), 32'(4'b0010));
        repeat (3) begin
            cycle(4'b1011, 1'b0, 1'b0);
            check_eq("s3_hold", 32'(bg), 32'(4'b0010));
        end
        cycle(4'b1001, 1'b0, 1'b0);
        check_eq("s3_turn", 32'(bg), 32'd0);
        cycle(4'b1001, 1'b0, 1'b0);
        check_eq("s3_next", 32'(bg), 32'(4'b1000));
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);

        // Watchdog revoke and lockout until BR drops.
        cycle(4'b0000, 1'b0, 1'b1);
        hi = 0;
        repeat (20) begin
            cycle(4'b0001, 1'b0, 1'b0);
            if (bg[0]) hi++;
        end
        check_eq("s4_hold", 32'(hi), 32'd16);
        check_eq("s4_err", 32'(err), 32'd1);
        repeat (5) begin
            cycle(4'b0001, 1'b0, 1'b0);
            check_eq("s4_locked", 32'(bg), 32'd0);
        end
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0001, 1'b0, 1'b0);
        check_eq("s4_regrant", 32'(bg), 32'(4'b0001));

        // Clear without timeout, then clear coincident with a timeout.
        cycle(4'b0001, 1'b1, 1'b0);
        check_eq("s5_clr", 32'(err), 32'd0);
        repeat (14) cycle(4'b0001, 1'b0, 1'b0);
        cycle(4'b0001, 1'b1, 1'b0);
        check_eq("s5_set", 32'(err), 32'd1);
        check_eq("s5_revoke", 32'(bg), 32'd0);

        // Reset mid-grant.
        cycle(4'b1001, 1'b0, 1'b0);
        check_eq("s6_pre", 32'(bg), 32'(4'b1000));
        cycle(4'b1001, 1'b0, 1'b1);
        check_eq("s6_bg", 32'(bg), 32'd0);
        check_eq("s6_owner", 32'(owner), 32'd0);
        check_eq("s6_err", 32'(err), 32'd0);
        cycle(4'b1001, 1'b0, 1'b0);
        check_eq("s6_first", 32'(bg), 32'(4'b0001));
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);

        // Random sticky request traffic.
        rb = '0;
        repeat (4000) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) rb[i] = ~rb[i];
            end
            cycle(rb, ($urandom_range(0, 15) == 0), ($urandom_range(0, 499) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter for the shared system bus (D/A/SIZE/RW).
- Receives BR from every bus controller (cache, DMA, I/O) and returns one-hot BG using round-robin priority.
- Holds a grant for the full multi-beat transfer and inserts one dead cycle between owners for tristate turnaround.
- A watchdog revokes a grant held too long and flags an error.

Parameters:
NUM_REQ, 4, number of requesting bus controllers (2..8)
TIMEOUT_CYCLES, 64, maximum consecutive cycles one owner may hold BG (2..255)
ID_W, 3, width of OWNER field; must satisfy 2^ID_W >= NUM_REQ

Ports:
BUS_CLK  in  1  bus clock; all state updates on rising edge
RST  in  1  reset; synchronous, active-high
BR  in  NUM_REQ  bus request per controller; held high until that controller's transfer completes
BG  out  NUM_REQ  bus grant, one-hot or zero, registered
BUS_BUSY  out  1  high while any BG is asserted
OWNER  out  ID_W  index of current/last granted requester
TIMEOUT_ERR  out  1  sticky; set when a grant is revoked by the watchdog
ERR_CLR  in  1  clears TIMEOUT_ERR (lower priority than a same-cycle set)

Behaviour:
- Reset (RST=1 at clock edge): state=IDLE, BG=0, BUS_BUSY=0, OWNER=0, rr pointer=0, hold timer=0, TIMEOUT_ERR=0, lockout mask=0. RST mid-grant drops BG on the next edge; no turnaround cycle.
- States (one-hot, 3 bits): IDLE=3'b001, GRANT=3'b010, TURN=3'b100.
- Eligible set = BR & ~lockout.
- Pick: first eligible index scanning ptr, ptr+1, ..., wrapping mod NUM_REQ.
- IDLE:
  - If eligible is nonzero: next state GRANT, BG<=onehot(pick), OWNER<=pick, timer<=0.
  - Latency: BR rising sampled at edge n gives BG high after edge n.
- GRANT:
  - BG held constant. Timer increments each cycle.
  - If BR[OWNER]=0: next state TURN, BG<=0, ptr<=(OWNER+1) mod NUM_REQ.
  - Else if timer==TIMEOUT_CYCLES-1: next state TURN, BG<=0, ptr<=OWNER+1, lockout[OWNER]<=1, TIMEOUT_ERR<=1.
  - Changes in other BR bits are ignored; no preemption.
- TURN:
  - BG=0 for exactly one cycle.
  - If eligible is nonzero, go to GRANT with the new pick. Otherwise go to IDLE.
  - Back-to-back owners therefore always see exactly one idle bus cycle between grants.
- Lockout: lockout[i] clears on any cycle where BR[i]=0. A timed-out controller is not re-granted until it drops and re-raises BR.
- BUS_BUSY equals OR of BG (registered alongside BG).
- OWNER keeps its last value in IDLE and TURN.
- Single requester: re-granted after one TURN cycle if it re-requests.
- NUM_REQ not a power of 2: ptr wraps from NUM_REQ-1 to 0. Indices >= NUM_REQ are never granted.
- ERR_CLR and a timeout in the same cycle leave TIMEOUT_ERR=1.
- BG is never multi-hot. Assertion: $onehot0(BG) every cycle.

Decomposition:
- Shared package: state encodings IDLE/GRANT/TURN, default NUM_REQ, TIMEOUT_CYCLES, ID_W, timer width (8).
- One sub-module: rr_pick (combinational rotate-priority encoder).
  - Inputs: eligible vector, ptr.
  - Outputs: valid, index.
  - Reusable by the memory-side request queue.
- FSM, timer, lockout and output registers stay in bus_arbiter.

Test Plan (NUM_REQ=4, TIMEOUT_CYCLES=16):
- Reset then BR=4'b0100 at cycle 2 -> BG=4'b0100 after edge 3, OWNER=2; hold BR 5 cycles then drop -> BG=0 next edge, ptr=3.
- BR=4'b1111 held continuously, each owner drops BR after 4 grant cycles -> grant order 0,1,2,3,0; exactly one BG=0 cycle between grants; BG never multi-hot.
- Owner 1 granted, BR=4'b1011 raised mid-transfer -> BG stays 4'b0010 until BR[1] drops; next grant goes to 3 (ptr=2, BR[2]=0), not 0.
- Owner 0 holds BR 20 cycles -> BG drops after 16 grant cycles, TIMEOUT_ERR=1; BR[0] still high and no one else requesting -> FSM returns to IDLE, no re-grant until BR[0] goes low for a cycle and rises again.
- ERR_CLR pulse with no timeout -> TIMEOUT_ERR=0. ERR_CLR coincident with a second timeout -> TIMEOUT_ERR stays 1.
- RST asserted while BG=4'b1000 -> next edge BG=0, OWNER=0, TIMEOUT_ERR=0; first request after reset (BR=4'b1001) is granted to 0.
